// File: rtl/cpu_types_pkg.sv
// Shared execute-stage operation encodings for the CPU datapath.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } aluop_t;

  typedef enum logic [1:0] {
    MULT, MULTU, DIV, DIVU
  } muldiv_op_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of LSB-first shift-add multiply or restoring
// shift-subtract divide over the {hi,lo} accumulator pair.
module muldiv_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              div_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic            ge;

  assign sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
  assign shifted = {hi_i, lo_i[DATA_W-1]};
  assign ge      = shifted >= {1'b0, b_i};

  // The partial remainder stays below the divisor, so the difference
  // always fits in DATA_W bits and the carry bit of shifted is only
  // needed for the compare.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (div_i) begin
      hi_o = ge ? (shifted[DATA_W-1:0] - b_i) : shifted[DATA_W-1:0];
      lo_o = {lo_i[DATA_W-2:0], ge};
    end else begin
      {hi_o, lo_o} = {sum, lo_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and a stall
// request for dependents of an in-flight result.
module ex_muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  muldiv_op_t        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  input  logic              read_hilo,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div0,
  output logic              stall_req
);

  localparam int unsigned N     = DATA_W / UNROLL;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              div0_q, div0_d;

  logic              in_signed, in_div, is_div;
  logic [DATA_W-1:0] rs_mag, rt_mag;
  logic [DATA_W-1:0] hi_c [UNROLL+1];
  logic [DATA_W-1:0] lo_c [UNROLL+1];
  logic [2*DATA_W-1:0] prod_mag, prod_res;
  logic [DATA_W-1:0] quot_res, rem_res;

  assign in_signed = (op == MULT) || (op == DIV);
  assign in_div    = (op == DIV)  || (op == DIVU);
  assign is_div    = (op_q == DIV) || (op_q == DIVU);
  assign rs_mag    = (in_signed && rs_val[DATA_W-1]) ? -rs_val : rs_val;
  assign rt_mag    = (in_signed && rt_val[DATA_W-1]) ? -rt_val : rt_val;

  assign hi_c[0] = acc_hi_q;
  assign lo_c[0] = acc_lo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.DATA_W(DATA_W)) u_step (
      .div_i (is_div),
      .hi_i  (hi_c[g]),
      .lo_i  (lo_c[g]),
      .b_i   (b_q),
      .hi_o  (hi_c[g+1]),
      .lo_o  (lo_c[g+1])
    );
  end

  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod_res = qneg_q ? -prod_mag : prod_mag;
  assign quot_res = qneg_q ? -acc_lo_q : acc_lo_q;
  assign rem_res  = rneg_q ? -acc_hi_q : acc_hi_q;

  // Divisor goes in b and dividend in the low accumulator for divides;
  // for multiplies the multiplier is consumed from the low accumulator.
  // A zero divisor leaves the remainder path holding rs_val, so only the
  // quotient needs overriding.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdat;
        if (lo_we) lo_d = wdat;
        if (start && !flush) begin
          state_d  = CALC;
          op_d     = op;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = in_div ? rs_mag : rt_mag;
          b_d      = in_div ? rt_mag : rs_mag;
          qneg_d   = in_signed && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
          rneg_d   = in_signed && rs_val[DATA_W-1];
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_hi_d = hi_c[UNROLL];
          acc_lo_d = lo_c[UNROLL];
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div) begin
            hi_d = rem_res;
            if (b_q == '0) begin
              lo_d   = '1;
              div0_d = 1'b1;
            end else begin
              lo_d = quot_res;
            end
          end else begin
            {hi_d, lo_d} = prod_res;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      op_q     <= MULT;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign div0      = div0_q;
  assign stall_req = busy && (start || read_hilo || hi_we || lo_we);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench: UNROLL=1 and UNROLL=4 instances against an
// arithmetic reference model.
module tb_ex_muldiv_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic start_a = 0, flush_a = 0, rd_a = 0, hiwe_a = 0, lowe_a = 0;
  muldiv_op_t op_a = MULT;
  logic [31:0] rs_a = 0, rt_a = 0, wdat_a = 0;
  logic [31:0] hi_a, lo_a;
  logic busy_a, done_a, div0_a, stall_a;

  logic start_b = 0, flush_b = 0, rd_b = 0, hiwe_b = 0, lowe_b = 0;
  muldiv_op_t op_b = MULT;
  logic [31:0] rs_b = 0, rt_b = 0, wdat_b = 0;
  logic [31:0] hi_b, lo_b;
  logic busy_b, done_b, div0_b, stall_b;

  int n_checks = 0;
  int n_pass = 0;

  ex_muldiv_unit #(.DATA_W(32), .UNROLL(1)) dut (
    .CLK(CLK), .nRST(nRST), .start(start_a), .op(op_a), .rs_val(rs_a), .rt_val(rt_a),
    .flush(flush_a), .read_hilo(rd_a), .hi_we(hiwe_a), .lo_we(lowe_a), .wdat(wdat_a),
    .hi(hi_a), .lo(lo_a), .busy(busy_a), .done(done_a), .div0(div0_a), .stall_req(stall_a)
  );

  ex_muldiv_unit #(.DATA_W(32), .UNROLL(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .start(start_b), .op(op_b), .rs_val(rs_b), .rt_val(rt_b),
    .flush(flush_b), .read_hilo(rd_b), .hi_we(hiwe_b), .lo_we(lowe_b), .wdat(wdat_b),
    .hi(hi_b), .lo(lo_b), .busy(busy_b), .done(done_b), .div0(div0_b), .stall_req(stall_b)
  );

  // MIPS HI/LO semantics computed with native 64-bit and 32-bit arithmetic.
  function automatic void model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output logic md0);
    longint p;
    longint unsigned pu;
    int sa, sb;
    md0 = 1'b0;
    mh = '0;
    ml = '0;
    case (o)
      MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {mh, ml} = p;
      end
      MULTU: begin
        pu = {32'b0, a} * {32'b0, b};
        {mh, ml} = pu;
      end
      default: begin
        if (b == 32'd0) begin
          ml = 32'hFFFF_FFFF; mh = a; md0 = 1'b1;
        end else if (o == DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          ml = 32'h8000_0000; mh = 32'd0;
        end else if (o == DIV) begin
          sa = a; sb = b;
          ml = sa / sb; mh = sa % sb;
        end else begin
          ml = a / b; mh = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = $urandom_range(0, 255);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one operation from an idle state and waits (bounded) for done.
  task automatic run_op(input bit u4, input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit busy_ok);
    if (u4) begin start_b = 1; op_b = o; rs_b = a; rt_b = b; end
    else    begin start_a = 1; op_a = o; rs_a = a; rt_a = b; end
    @(posedge CLK); #1;
    start_a = 0; start_b = 0;
    cyc = 0;
    busy_ok = 1;
    while ((u4 ? done_b : done_a) !== 1'b1 && cyc < 200) begin
      if ((u4 ? busy_b : busy_a) !== 1'b1) busy_ok = 0;
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (hi_a !== 0 || lo_a !== 0) $display("FAIL reset_hilo got %h/%h exp 0/0", hi_a, lo_a); else n_pass++;
    n_checks++; if (busy_a !== 0 || done_a !== 0 || div0_a !== 0) $display("FAIL reset_flags got %b%b%b exp 000", busy_a, done_a, div0_a); else n_pass++;
    n_checks++; if (stall_a !== 0) $display("FAIL reset_stall got %b exp 0", stall_a); else n_pass++;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic test_directed();
    muldiv_op_t ops [5] = '{MULTU, MULT, DIV, DIVU, DIV};
    logic [31:0] as [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] eh, el;
    logic ed;
    int cyc;
    bit bok;
    for (int i = 0; i < 5; i++) begin
      model(ops[i], as[i], bs[i], eh, el, ed);
      run_op(0, ops[i], as[i], bs[i], cyc, bok);
      n_checks++; if (cyc !== 33) $display("FAIL dir%0d_latency got %0d exp 33", i, cyc); else n_pass++;
      n_checks++; if (!bok) $display("FAIL dir%0d_busy got low exp high", i); else n_pass++;
      n_checks++; if (hi_a !== eh) $display("FAIL dir%0d_hi got %h exp %h", i, hi_a, eh); else n_pass++;
      n_checks++; if (lo_a !== el) $display("FAIL dir%0d_lo got %h exp %h", i, lo_a, el); else n_pass++;
      n_checks++; if (div0_a !== ed) $display("FAIL dir%0d_div0 got %b exp %b", i, div0_a, ed); else n_pass++;
      n_checks++; if (busy_a !== 0) $display("FAIL dir%0d_busy_done got %b exp 0", i, busy_a); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if (done_a !== 0 || div0_a !== 0) $display("FAIL dir%0d_pulse got %b%b exp 00", i, done_a, div0_a); else n_pass++;
    end
  endtask

  task automatic test_random(input bit u4, input int count);
    logic [31:0] a, b, eh, el;
    logic ed;
    muldiv_op_t o;
    int cyc, lat;
    bit bok;
    lat = u4 ? 9 : 33;
    for (int i = 0; i < count; i++) begin
      o = muldiv_op_t'($urandom_range(0, 3));
      a = pick();
      b = pick();
      model(o, a, b, eh, el, ed);
      run_op(u4, o, a, b, cyc, bok);
      n_checks++; if (cyc !== lat) $display("FAIL rnd%0d_u%0d_latency got %0d exp %0d", i, u4, cyc, lat); else n_pass++;
      n_checks++; if ((u4 ? hi_b : hi_a) !== eh) $display("FAIL rnd%0d_u%0d_hi op %0d %h,%h got %h exp %h", i, u4, o, a, b, u4 ? hi_b : hi_a, eh); else n_pass++;
      n_checks++; if ((u4 ? lo_b : lo_a) !== el) $display("FAIL rnd%0d_u%0d_lo op %0d %h,%h got %h exp %h", i, u4, o, a, b, u4 ? lo_b : lo_a, el); else n_pass++;
      n_checks++; if ((u4 ? div0_b : div0_a) !== ed) $display("FAIL rnd%0d_u%0d_div0 got %b exp %b", i, u4, u4 ? div0_b : div0_a, ed); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh, el;
    logic ed;
    int cyc;
    bit bok;
    run_op(0, MULTU, 32'd1000, 32'd3000, cyc, bok);
    model(DIVU, 32'd1000, 32'd7, eh, el, ed);
    run_op(0, DIVU, 32'd1000, 32'd7, cyc, bok);
    n_checks++; if (cyc !== 33) $display("FAIL b2b_latency got %0d exp 33", cyc); else n_pass++;
    n_checks++; if (hi_a !== eh || lo_a !== el) $display("FAIL b2b_result got %h/%h exp %h/%h", hi_a, lo_a, eh, el); else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] lo_save;
    bit seen;
    hiwe_a = 1; wdat_a = 32'h11;
    @(posedge CLK); #1;
    hiwe_a = 0;
    n_checks++; if (hi_a !== 32'h11) $display("FAIL mthi_idle got %h exp 00000011", hi_a); else n_pass++;
    lo_save = lo_a;
    start_a = 1; op_a = DIV; rs_a = 32'd100; rt_a = 32'd7;
    @(posedge CLK); #1;
    start_a = 0;
    repeat (10) begin @(posedge CLK); #1; end
    n_checks++; if (busy_a !== 1) $display("FAIL flush_pre_busy got %b exp 1", busy_a); else n_pass++;
    flush_a = 1;
    @(posedge CLK); #1;
    flush_a = 0;
    n_checks++; if (busy_a !== 0) $display("FAIL flush_busy got %b exp 0", busy_a); else n_pass++;
    n_checks++; if (hi_a !== 32'h11 || lo_a !== lo_save) $display("FAIL flush_hilo got %h/%h exp 00000011/%h", hi_a, lo_a, lo_save); else n_pass++;
    seen = 0;
    repeat (40) begin if (done_a) seen = 1; @(posedge CLK); #1; end
    n_checks++; if (seen) $display("FAIL flush_done got 1 exp 0"); else n_pass++;
    start_a = 1; flush_a = 1; op_a = MULTU; rs_a = 32'd5; rt_a = 32'd5;
    @(posedge CLK); #1;
    start_a = 0; flush_a = 0;
    n_checks++; if (busy_a !== 0) $display("FAIL flush_start_busy got %b exp 0", busy_a); else n_pass++;
    seen = 0;
    repeat (40) begin if (done_a || busy_a) seen = 1; @(posedge CLK); #1; end
    n_checks++; if (seen || hi_a !== 32'h11) $display("FAIL flush_start_noop got seen=%b hi=%h exp 0/00000011", seen, hi_a); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] a, b, eh, el;
    logic ed;
    bit stall_ok, hi_ok;
    int cyc;
    rd_a = 1; #1;
    n_checks++; if (stall_a !== 0) $display("FAIL stall_idle got %b exp 0", stall_a); else n_pass++;
    rd_a = 0;
    a = $urandom; b = $urandom;
    model(MULT, a, b, eh, el, ed);
    start_a = 1; op_a = MULT; rs_a = a; rt_a = b;
    @(posedge CLK); #1;
    start_a = 0; rd_a = 1; hiwe_a = 1; wdat_a = 32'hABCD; #1;
    stall_ok = 1; hi_ok = 1; cyc = 0;
    while (done_a !== 1'b1 && cyc < 200) begin
      if (stall_a !== 1'b1) stall_ok = 0;
      if (hi_a !== 32'h11) hi_ok = 0;
      @(posedge CLK); #1;
      cyc++;
    end
    n_checks++; if (!stall_ok) $display("FAIL stall_busy got 0 exp 1"); else n_pass++;
    n_checks++; if (!hi_ok) $display("FAIL stall_mthi_blocked got changed exp 00000011"); else n_pass++;
    n_checks++; if (hi_a !== eh || lo_a !== el) $display("FAIL stall_result got %h/%h exp %h/%h", hi_a, lo_a, eh, el); else n_pass++;
    n_checks++; if (stall_a !== 0) $display("FAIL stall_at_done got %b exp 0", stall_a); else n_pass++;
    @(posedge CLK); #1;
    rd_a = 0; hiwe_a = 0;
    n_checks++; if (hi_a !== 32'hABCD || lo_a !== el) $display("FAIL mthi_after_done got %h/%h exp 0000abcd/%h", hi_a, lo_a, el); else n_pass++;
  endtask

  task automatic test_unroll4();
    int cyc;
    bit bok;
    run_op(1, MULTU, 32'h1234, 32'h10, cyc, bok);
    n_checks++; if (cyc !== 9) $display("FAIL u4_latency got %0d exp 9", cyc); else n_pass++;
    n_checks++; if (lo_b !== 32'h12340 || hi_b !== 0) $display("FAIL u4_multu got %h/%h exp 00000000/00012340", hi_b, lo_b); else n_pass++;
    test_random(1, 12);
  endtask

  task automatic test_reset_mid();
    logic [31:0] eh, el;
    logic ed;
    int cyc;
    bit bok;
    run_op(1, MULTU, 32'hFFFF, 32'hFFFF, cyc, bok);
    start_b = 1; op_b = DIV; rs_b = 32'hFFFF_FF00; rt_b = 32'd3;
    @(posedge CLK); #1;
    start_b = 0;
    repeat (3) begin @(posedge CLK); #1; end
    nRST = 0; #1;
    n_checks++; if (hi_b !== 0 || lo_b !== 0) $display("FAIL rstmid_hilo got %h/%h exp 0/0", hi_b, lo_b); else n_pass++;
    n_checks++; if (busy_b !== 0 || done_b !== 0 || div0_b !== 0 || stall_b !== 0)
      $display("FAIL rstmid_flags got %b%b%b%b exp 0000", busy_b, done_b, div0_b, stall_b); else n_pass++;
    @(posedge CLK); #1;
    nRST = 1;
    model(DIV, 32'hFFFF_FF00, 32'd3, eh, el, ed);
    run_op(1, DIV, 32'hFFFF_FF00, 32'd3, cyc, bok);
    n_checks++; if (cyc !== 9) $display("FAIL rstmid_latency got %0d exp 9", cyc); else n_pass++;
    n_checks++; if (hi_b !== eh || lo_b !== el) $display("FAIL rstmid_result got %h/%h exp %h/%h", hi_b, lo_b, eh, el); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(0, 24);
    test_back_to_back();
    test_flush();
    test_stall();
    test_unroll4();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage, with HI/LO result registers. It executes MULT, MULTU, DIV and DIVU over several cycles and signals a pipeline stall request while a dependent instruction needs a result that is still in flight. It also services MTHI/MTLO writes and MFHI/MFLO reads. It sits beside the ALU in the execute stage, and its stall request feeds the hazard unit together with the existing load-use and jump-use stalls.

## Interface
Parameters:
- DATA_W, 32, operand width; also the width of HI and LO.
- UNROLL, 1, iteration bits per cycle; must divide DATA_W. N = DATA_W/UNROLL.

Ports:
- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous, active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  muldiv_op_t  MULT, MULTU, DIV or DIVU; sampled with start
- rs_val  in  DATA_W  multiplicand or dividend
- rt_val  in  DATA_W  multiplier or divisor
- flush  in  1  abort the in-flight operation (branch/jump squash)
- read_hilo  in  1  an MFHI or MFLO is in EX
- hi_we, lo_we  in  1  MTHI/MTLO write enables
- wdat  in  DATA_W  data for MTHI/MTLO
- hi, lo  out  DATA_W  HI/LO registers
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when new HI/LO values are visible
- div0  out  1  qualifies done; the completed op was a divide with rt_val == 0
- stall_req  out  1  busy & (start | read_hilo | hi_we | lo_we)

## Operation
- States: IDLE, CALC, FIX.
- IDLE → CALC on start & !flush.
  - Latch op.
  - Latch |rs_val| and |rt_val|; magnitudes are taken only for the signed ops.
  - Latch the result signs:
    - Product and quotient sign = sign(rs) ^ sign(rt).
    - Remainder sign = sign(rs).
  - Clear the iteration counter.
- CALC: perform UNROLL shift-add (multiply) or restoring shift-subtract (divide) steps per cycle. After N cycles, go to FIX.
- FIX:
  - Apply the sign correction.
  - Multiply: {hi,lo} ← 2·DATA_W product.
  - Divide: lo ← quotient, hi ← remainder.
  - Go to IDLE and assert done for one cycle.
- Divide by zero:
  - Takes the full latency.
  - Result: lo = all ones, hi = rs_val (unmodified), div0 = 1 with done.
- Signed overflow (most-negative / −1): lo = most-negative, hi = 0. This falls out of the unsigned magnitude path; no special case is needed.
- hi_we/lo_we:
  - In IDLE, the register is written at the edge.
  - In CALC or FIX, the write is not performed and stall_req holds the pipeline.
- start while busy: ignored; stall_req holds the requester.
- flush:
  - In CALC or FIX: return to IDLE at the next edge. hi and lo are unchanged and no done pulse occurs.
  - flush & start in the same IDLE cycle: start is ignored.
- Reset (any time, including mid-operation): state = IDLE; hi = lo = 0; busy = done = div0 = 0; counter = 0.

## Timing
- Latency: start accepted at edge 0; CALC spans edges 1..N; FIX writes at edge N+1.
  - done is high for the cycle after edge N+1.
  - busy is high after edges 0..N and low after edge N+1.
  - DATA_W=32, UNROLL=1: 33 cycles. UNROLL=4: 9 cycles.
- Back-to-back: a new start may be accepted in the same cycle done is high.
- stall_req is combinational from busy and the inputs. No other output has a combinational path from an input.
- hi and lo change only at the FIX edge, at an IDLE MTHI/MTLO edge, or on reset.

## Structure
- muldiv_op_t (2-bit enum) goes in cpu_types_pkg next to aluop_t.
- The FSM state enum is local to the module.
- Sub-module muldiv_step: one combinational iteration slice for multiply or divide, parametrised by DATA_W. It is instantiated UNROLL times in a generate chain.
- Target size: about 200–300 lines total.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done in the 33rd cycle after start; busy is high throughout.
- MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7 / 0 → lo=0xFFFFFFFF, hi=0x00000007, div0=1 with done. DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- Preload hi=0x11 via MTHI. Start DIV, then flush 10 cycles later → busy low after the next edge, hi stays 0x11, no done. flush & start together in IDLE → no operation starts.
- Start MULT, then read_hilo and hi_we while busy → stall_req=1 until done. The MTHI applied after done overwrites hi.
- UNROLL=4: MULTU 0x1234 × 0x10 → lo=0x12340, done 9 cycles after start. Deassert nRST mid-CALC → all outputs 0, IDLE, and the next start works normally.
